// File: rtl/cond_eval_unit.sv
// NZCV flag register with a one-deep shadow, feeding LANES parallel ARM-style
// condition checks that see the same-cycle (bypassed) next flags.

module cond_lane (
    input  logic       vld,
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic       n, z, c, v;
    logic [3:0] cc;

    always_comb begin
        {n, z, c, v} = flags;
        // Invalid lanes evaluate NV, so an undriven cond never reaches pass
        cc   = vld ? cond : 4'hF;
        pass = 1'b0;
        case (cc)
            4'h0: pass = z;
            4'h1: pass = !z;
            4'h2: pass = c;
            4'h3: pass = !c;
            4'h4: pass = n;
            4'h5: pass = !n;
            4'h6: pass = v;
            4'h7: pass = !v;
            4'h8: pass = c & !z;
            4'h9: pass = !c | z;
            4'hA: pass = (n == v);
            4'hB: pass = (n != v);
            4'hC: pass = !z & (n == v);
            4'hD: pass = z | (n != v);
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

module cond_eval_unit #(
    parameter int         LANES    = 2,
    parameter bit         REG_OUT  = 1'b1,
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flag_we,
    input  logic [3:0]           flag_mask,
    input  logic [3:0]           flag_wdata,
    input  logic                 save_en,
    input  logic                 restore_en,
    input  logic                 stall,
    input  logic [LANES-1:0]     cond_valid,
    input  logic [4*LANES-1:0]   cond,
    output logic [LANES-1:0]     pass_valid,
    output logic [LANES-1:0]     pass,
    output logic [3:0]           nzcv
);
    logic [3:0]       shadow;
    logic [3:0]       nf;
    logic [LANES-1:0] pass_c;

    // Restore wins over an ALU write in the same cycle
    always_comb begin
        nf = nzcv;
        if (restore_en)
            nf = shadow;
        else if (flag_we)
            nf = (nzcv & ~flag_mask) | (flag_wdata & flag_mask);
    end

    // Shadow captures the pre-write flags; save+restore together is a swap
    always_ff @(posedge clk) begin
        if (rst) begin
            nzcv   <= FLAG_RST;
            shadow <= FLAG_RST;
        end else begin
            nzcv <= nf;
            if (save_en)
                shadow <= nzcv;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cond_lane u_lane (
            .vld   (cond_valid[i]),
            .cond  (cond[4*i +: 4]),
            .flags (nf),
            .pass  (pass_c[i])
        );
    end

    if (REG_OUT) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                pass       <= '0;
                pass_valid <= '0;
            end else if (!stall) begin
                pass       <= pass_c;
                pass_valid <= cond_valid;
            end
        end
    end else begin : g_comb
        assign pass       = pass_c;
        assign pass_valid = cond_valid;
    end
endmodule

// File: tb/tb_cond_eval_unit.sv
// Randomized + directed bench for cond_eval_unit (LANES=2, REG_OUT=1) with a
// flag-level reference model and a cycle-tagged scoreboard.

module tb_cond_eval_unit;
    localparam int         LANES    = 2;
    localparam logic [3:0] FLAG_RST = 4'b0000;

    logic             clk = 1'b0;
    logic             rst;
    logic             flag_we, save_en, restore_en, stall;
    logic [3:0]       flag_mask, flag_wdata;
    logic [LANES-1:0] cond_valid;
    logic [4*LANES-1:0] cond;
    logic [LANES-1:0] pass_valid, pass;
    logic [3:0]       nzcv;

    cond_eval_unit #(.LANES(LANES), .REG_OUT(1'b1), .FLAG_RST(FLAG_RST)) dut (
        .clk(clk), .rst(rst), .flag_we(flag_we), .flag_mask(flag_mask),
        .flag_wdata(flag_wdata), .save_en(save_en), .restore_en(restore_en),
        .stall(stall), .cond_valid(cond_valid), .cond(cond),
        .pass_valid(pass_valid), .pass(pass), .nzcv(nzcv)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               due;
        logic [LANES-1:0] pv;
        logic [LANES-1:0] ps;
        logic [3:0]       fl;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    logic [3:0]       m_flags = FLAG_RST;
    logic [3:0]       m_shadow = FLAG_RST;
    logic [LANES-1:0] m_pv = '0;
    logic [LANES-1:0] m_ps = '0;

    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        // Even codes are the positive sense, odd codes invert (except AL/NV)
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    // Apply current inputs to the model, queue the response due after the next edge
    task automatic step();
        exp_t e;
        logic [3:0] nf;
        if (rst) begin
            m_flags = FLAG_RST; m_shadow = FLAG_RST; m_pv = '0; m_ps = '0;
        end else begin
            if (restore_en)   nf = m_shadow;
            else if (flag_we) begin
                nf = m_flags;
                for (int b = 0; b < 4; b++) if (flag_mask[b]) nf[b] = flag_wdata[b];
            end else          nf = m_flags;
            if (!stall) begin
                for (int l = 0; l < LANES; l++) begin
                    m_pv[l] = cond_valid[l];
                    m_ps[l] = cond_valid[l] && cond_true(cond[4*l +: 4], nf);
                end
            end
            if (save_en) m_shadow = m_flags;
            m_flags = nf;
        end
        e.due = cyc + 1; e.pv = m_pv; e.ps = m_ps; e.fl = m_flags;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; flag_we = 0; save_en = 0; restore_en = 0; stall = 0;
        flag_mask = 4'h0; flag_wdata = 4'h0; cond_valid = '0; cond = '0;
    endtask

    task automatic set_flags(input logic [3:0] f);
        idle(); flag_we = 1; flag_mask = 4'hF; flag_wdata = f; step();
    endtask

    // Monitor: compares outputs at the negedge the queued entry is due
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_pass_valid", {6'd0, pass_valid}, {6'd0, e.pv});
            chk("sb_pass",       {6'd0, pass},       {6'd0, e.ps});
            chk("sb_nzcv",       {4'd0, nzcv},       {4'd0, e.fl});
        end
    end

    initial begin
        idle();
        rst = 1;
        @(posedge clk); #1;

        // Reset dominates a simultaneous full flag write
        rst = 1; flag_we = 1; flag_wdata = 4'hF; flag_mask = 4'hF;
        step(); step();
        chk("reset_nzcv", {4'd0, nzcv}, 8'h00);
        chk("reset_pass", {6'd0, pass}, 8'h00);
        chk("reset_pv",   {6'd0, pass_valid}, 8'h00);

        // Exhaustive cond x flags, flags arriving via same-cycle bypass
        for (int f = 0; f < 16; f++)
            for (int c = 0; c < 16; c++) begin
                idle(); flag_we = 1; flag_mask = 4'hF; flag_wdata = f[3:0];
                cond_valid = 2'b11; cond = {4'(15 - c), c[3:0]};
                step();
            end

        // Bypass: Z written and EQ evaluated in the same cycle
        set_flags(4'b0000);
        idle(); flag_we = 1; flag_mask = 4'b0100; flag_wdata = 4'b0100;
        cond_valid = 2'b01; cond = 8'h00;
        step();
        chk("bypass_pass", {6'd0, pass}, 8'h01);
        chk("bypass_nzcv", {4'd0, nzcv}, 8'h04);

        // Mask: only N,Z cleared; HI true, GE false since N=0,V=1
        set_flags(4'b1111);
        idle(); flag_we = 1; flag_mask = 4'b1100; flag_wdata = 4'b0000;
        cond_valid = 2'b11; cond = {4'hA, 4'h8};
        step();
        chk("mask_nzcv", {4'd0, nzcv}, 8'h03);
        chk("mask_hi_ge", {6'd0, pass}, 8'h01);

        // Save / restore / swap
        set_flags(4'b1010);
        idle(); save_en = 1; step();
        set_flags(4'b0101);
        idle(); restore_en = 1; flag_we = 1; flag_mask = 4'hF; flag_wdata = 4'hF; step();
        chk("restore_nzcv", {4'd0, nzcv}, 8'h0A);
        set_flags(4'b0101);
        idle(); save_en = 1; restore_en = 1; step();
        chk("swap_nzcv", {4'd0, nzcv}, 8'h0A);
        idle(); restore_en = 1; step();
        chk("swap_shadow", {4'd0, nzcv}, 8'h05);

        // Stall holds AL result; NV presented during stall is dropped
        idle(); cond_valid = 2'b01; cond = 8'h0E; step();
        idle(); stall = 1; cond_valid = 2'b01; cond = 8'h0F; step();
        chk("stall_hold_pass", {6'd0, pass}, 8'h01);
        chk("stall_hold_pv",   {6'd0, pass_valid}, 8'h01);
        idle(); cond_valid = 2'b10; cond = 8'hF0; step();
        chk("post_stall_pass", {6'd0, pass}, 8'h00);
        chk("post_stall_pv",   {6'd0, pass_valid}, 8'h02);

        // Random traffic including occasional reset and stall
        for (int k = 0; k < 600; k++) begin
            rst        = ($urandom_range(0, 49) == 0);
            flag_we    = $urandom_range(0, 1);
            flag_mask  = 4'($urandom);
            flag_wdata = 4'($urandom);
            save_en    = ($urandom_range(0, 5) == 0);
            restore_en = ($urandom_range(0, 5) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            cond_valid = 2'($urandom);
            cond       = 8'($urandom);
            step();
        end

        idle();
        for (int w = 0; w < 5 && sb.size() > 0; w++) @(posedge clk);
        #1;
        chk("sb_drained", 8'(sb.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
